put_get_inverter_fifo: RTL and testbench

- Buffered, parametrised successor to the combinational put-to-get inverter.
- Accepts data on a Put-style interface (put/EN_put/RDY_put) and presents it on a Get-style interface (get/EN_get/RDY_get) through a DEPTH-entry FIFO.
- Every RDY output is a function of registered state only. There is no combinational path from any EN input to any RDY output, so the block is safe to drop between BSV-generated modules whose EN is derived from RDY.
- Provides real backpressure on RDY_put instead of an always-ready sink.

---
 rtl/put_get_inverter_fifo.sv | 72 +++++++
 tb/tb_put_get_inverter_fifo.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/put_get_inverter_fifo.sv
// put_get_inverter_fifo: DEPTH-entry FIFO bridging a Put interface to a Get interface with registered-only RDY outputs.
//   CLK, RST (async active-low); put/EN_put/RDY_put enqueue side; get/EN_get/RDY_get dequeue side;
//   count = occupancy, almost_full = count >= AFULL_LEVEL; err_overflow/err_underflow are sticky
//   protocol-error flags that exist only when PUT_GET_INVERTER_ERR_EN is defined (tied 0 otherwise).
module put_get_inverter_fifo #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 4,
  parameter int AFULL_LEVEL = DEPTH - 1
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [DATA_WIDTH-1:0]        put,
  input  logic                         EN_put,
  output logic                         RDY_put,
  output logic [DATA_WIDTH-1:0]        get,
  input  logic                         EN_get,
  output logic                         RDY_get,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         almost_full,
  output logic                         err_overflow,
  output logic                         err_underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [PW-1:0] wptr, rptr;
  logic live;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic full, empty, enq, deq;
  assign empty = wptr == rptr;
  assign full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  // live holds RDY_put low through reset and the first edge after release
  assign RDY_put = live && !full;
  assign RDY_get = !empty;
  assign enq = EN_put && RDY_put;
  assign deq = EN_get && RDY_get;
  assign get = mem[rptr[AW-1:0]];
  assign count = CW'(wptr - rptr);
  assign almost_full = count >= CW'(AFULL_LEVEL);
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      wptr <= '0;
      rptr <= '0;
      live <= 1'b0;
    end else begin
      live <= 1'b1;
      if (enq) wptr <= wptr + PW'(1);
      if (deq) rptr <= rptr + PW'(1);
    end
  always_ff @(posedge CLK)
    if (enq) mem[wptr[AW-1:0]] <= put;
`ifdef PUT_GET_INVERTER_ERR_EN
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (EN_put && !RDY_put) err_overflow <= 1'b1;
      if (EN_get && !RDY_get) err_underflow <= 1'b1;
    end
`ifndef SYNTHESIS
  always @(posedge CLK)
    if (RST) begin
      if (EN_put && !RDY_put) $display("put_get_inverter_fifo warning: EN_put while RDY_put=0 at %0t", $time);
      if (EN_get && !RDY_get) $display("put_get_inverter_fifo warning: EN_get while RDY_get=0 at %0t", $time);
    end
`endif
`else
  assign err_overflow  = 1'b0;
  assign err_underflow = 1'b0;
`endif
endmodule

// File: tb/tb_put_get_inverter_fifo.sv
// tb_put_get_inverter_fifo: directed self-checking bench for put_get_inverter_fifo (DEPTH=4).
module tb_put_get_inverter_fifo;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic [31:0] put = '0;
  logic EN_put = 1'b0;
  logic RDY_put;
  logic [31:0] get;
  logic EN_get = 1'b0;
  logic RDY_get;
  logic [2:0] count;
  logic almost_full, err_overflow, err_underflow;
  int checks = 0;
  int errors = 0;
`ifdef PUT_GET_INVERTER_ERR_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif
  put_get_inverter_fifo #(.DATA_WIDTH(32), .DEPTH(4), .AFULL_LEVEL(3)) dut (
    .CLK(CLK), .RST(RST), .put(put), .EN_put(EN_put), .RDY_put(RDY_put),
    .get(get), .EN_get(EN_get), .RDY_get(RDY_get), .count(count),
    .almost_full(almost_full), .err_overflow(err_overflow), .err_underflow(err_underflow)
  );
  always #5 CLK = ~CLK;
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic test_reset;
    tick;
    tick;
    checks++; if (RDY_put !== 1'b0) begin errors++; $display("FAIL rst_rdy_put got %b exp 0", RDY_put); end
    checks++; if (RDY_get !== 1'b0) begin errors++; $display("FAIL rst_rdy_get got %b exp 0", RDY_get); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", count); end
    checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL rst_afull got %b exp 0", almost_full); end
    RST = 1'b1;
    tick;
    checks++; if (RDY_put !== 1'b1) begin errors++; $display("FAIL idle_rdy_put got %b exp 1", RDY_put); end
    checks++; if (RDY_get !== 1'b0) begin errors++; $display("FAIL idle_rdy_get got %b exp 0", RDY_get); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL idle_count got %0d exp 0", count); end
    checks++; if ({err_overflow, err_underflow} !== 2'b00) begin errors++; $display("FAIL idle_err got %b exp 00", {err_overflow, err_underflow}); end
  endtask
  task automatic test_single;
    put = 32'hDEADBEEF; EN_put = 1'b1;
    tick;
    EN_put = 1'b0;
    checks++; if (RDY_get !== 1'b1) begin errors++; $display("FAIL single_rdy_get got %b exp 1", RDY_get); end
    checks++; if (get !== 32'hDEADBEEF) begin errors++; $display("FAIL single_get got %h exp deadbeef", get); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count got %0d exp 1", count); end
    EN_get = 1'b1;
    tick;
    EN_get = 1'b0;
    checks++; if (RDY_get !== 1'b0) begin errors++; $display("FAIL single_after_rdy_get got %b exp 0", RDY_get); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL single_after_count got %0d exp 0", count); end
  endtask
  task automatic test_fill;
    for (int i = 1; i <= 4; i++) begin
      put = i; EN_put = 1'b1;
      tick;
      checks++; if (count !== 3'(i)) begin errors++; $display("FAIL fill_count got %0d exp %0d", count, i); end
      checks++; if (almost_full !== (i >= 3)) begin errors++; $display("FAIL fill_afull got %b exp %b at %0d", almost_full, i >= 3, i); end
    end
    EN_put = 1'b0;
    checks++; if (RDY_put !== 1'b0) begin errors++; $display("FAIL full_rdy_put got %b exp 0", RDY_put); end
    put = 5; EN_put = 1'b1;
    tick;
    EN_put = 1'b0;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_ignore_count got %0d exp 4", count); end
    checks++; if (err_overflow !== ERR) begin errors++; $display("FAIL err_overflow got %b exp %b", err_overflow, ERR); end
    for (int i = 1; i <= 4; i++) begin
      checks++; if (get !== 32'(i)) begin errors++; $display("FAIL drain_get got %0d exp %0d", get, i); end
      EN_get = 1'b1;
      tick;
    end
    EN_get = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL drain_count got %0d exp 0", count); end
  endtask
  task automatic test_full_deq;
    for (int i = 10; i <= 13; i++) begin
      put = i; EN_put = 1'b1;
      tick;
    end
    EN_put = 1'b0;
    EN_get = 1'b1;
    #1;
    checks++; if (RDY_put !== 1'b0) begin errors++; $display("FAIL fulldeq_k_rdy_put got %b exp 0", RDY_put); end
    tick;
    EN_get = 1'b0;
    checks++; if (RDY_put !== 1'b1) begin errors++; $display("FAIL fulldeq_k1_rdy_put got %b exp 1", RDY_put); end
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL fulldeq_count got %0d exp 3", count); end
    checks++; if (get !== 32'd11) begin errors++; $display("FAIL fulldeq_get got %0d exp 11", get); end
    EN_get = 1'b1;
    tick; tick; tick;
    EN_get = 1'b0;
    checks++; if (RDY_get !== 1'b0) begin errors++; $display("FAIL fulldeq_empty got %b exp 0", RDY_get); end
  endtask
  task automatic test_back_to_back;
    int nw, nr;
    nw = 100; nr = 100;
    for (int i = 0; i < 2; i++) begin
      put = nw; nw++; EN_put = 1'b1;
      tick;
    end
    for (int c = 0; c < 20; c++) begin
      checks++; if (get !== 32'(nr)) begin errors++; $display("FAIL stream_get got %0d exp %0d", get, nr); end
      put = nw; nw++; EN_put = 1'b1; EN_get = 1'b1; nr++;
      tick;
      checks++; if (count !== 3'd2) begin errors++; $display("FAIL stream_count got %0d exp 2", count); end
    end
    EN_put = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++; if (get !== 32'(nr)) begin errors++; $display("FAIL stream_tail got %0d exp %0d", get, nr); end
      nr++;
      tick;
    end
    EN_get = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL stream_end_count got %0d exp 0", count); end
  endtask
  task automatic test_underflow;
    EN_get = 1'b1;
    tick;
    EN_get = 1'b0;
    checks++; if (err_underflow !== ERR) begin errors++; $display("FAIL err_underflow got %b exp %b", err_underflow, ERR); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL underflow_count got %0d exp 0", count); end
    tick;
    checks++; if (err_underflow !== ERR) begin errors++; $display("FAIL err_underflow_hold got %b exp %b", err_underflow, ERR); end
  endtask
  task automatic test_reset_mid;
    for (int i = 0; i < 3; i++) begin
      put = 32'(i + 7); EN_put = 1'b1;
      tick;
    end
    EN_put = 1'b0;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL mid_pre_count got %0d exp 3", count); end
    RST = 1'b0;
    #1;
    checks++; if (RDY_get !== 1'b0) begin errors++; $display("FAIL mid_rdy_get got %b exp 0", RDY_get); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL mid_count got %0d exp 0", count); end
    checks++; if (RDY_put !== 1'b0) begin errors++; $display("FAIL mid_rdy_put got %b exp 0", RDY_put); end
    checks++; if ({err_overflow, err_underflow} !== 2'b00) begin errors++; $display("FAIL mid_err got %b exp 00", {err_overflow, err_underflow}); end
    tick;
    RST = 1'b1;
    tick;
    checks++; if (RDY_put !== 1'b1) begin errors++; $display("FAIL mid_release_rdy_put got %b exp 1", RDY_put); end
    checks++; if (RDY_get !== 1'b0) begin errors++; $display("FAIL mid_release_rdy_get got %b exp 0", RDY_get); end
  endtask
  initial begin
    test_reset;
    test_single;
    test_fill;
    test_full_deq;
    test_back_to_back;
    test_underflow;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
